sa_ctrl: RTL
============

SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 SHALL have parameter S, default 64: PE row count of the controlled systolic array, which is its pipeline depth in shift steps.
REQ-002 SHALL have parameter ROWS_W, default 8: width of the row count and row index.
REQ-003 SHALL have port I_CLK, input, 1 bit: clock.
REQ-004 SHALL have port I_RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port I_CMD_VLD, input, 1 bit: job request.
REQ-006 SHALL have port O_CMD_RDY, output, 1 bit: controller idle, can accept a job.
REQ-007 SHALL have port I_CMD_ROWS, input, ROWS_W bits: M, the number of X vectors in the job.
REQ-008 SHALL have port O_SA_START, output, 1 bit: one-cycle start pulse to the array.
REQ-009 SHALL have port O_SA_END, output, 1 bit: one-cycle end pulse to the array.
REQ-010 SHALL have port I_SA_SHIFT, input, 1 bit: array step pulse (PE update done).
REQ-011 SHALL have port O_RD_ADDR, output, ROWS_W bits: X-buffer row index presented to the array.
REQ-012 SHALL have port O_X_ZERO, output, 1 bit: upstream forces X to zero (drain).
REQ-013 SHALL have port O_Y_VLD, output, 1 bit: array output row valid this cycle.
REQ-014 SHALL have port O_Y_IDX, output, ROWS_W bits: result row index for O_Y_VLD.
REQ-015 SHALL have port O_DONE, output, 1 bit: one-cycle job-complete pulse.
REQ-016 SHALL have port O_BUSY, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement the states IDLE, START, FEED, DRAIN and FINISH; O_CMD_RDY SHALL be high only in IDLE.
REQ-018 SHALL accept a job when I_CMD_VLD and O_CMD_RDY are both high in the same cycle: latch M, clear all counters, go to START; I_CMD_VLD outside IDLE SHALL be ignored.
REQ-019 SHALL, for an accepted job with M=0, go directly to FINISH and pulse O_DONE the next cycle, with no O_SA_START and no O_SA_END.
REQ-020 SHALL assert O_SA_START for exactly the one START cycle, then enter FEED.
REQ-021 SHALL, in FEED, drive O_RD_ADDR = feed_cnt (starting at 0) and increment feed_cnt on each I_SA_SHIFT; on the M-th shift it SHALL enter DRAIN, with O_RD_ADDR held at M-1.
REQ-022 SHALL hold O_X_ZERO high in DRAIN; on the S-th drain shift it SHALL enter FINISH.
REQ-023 SHALL number the shift pulses of a job j=1..M+S; for j>S it SHALL assert O_Y_VLD for one cycle in the cycle after pulse j, with O_Y_IDX = j-S-1, and O_Y_IDX SHALL increase by exactly 1 per O_Y_VLD.
REQ-024 SHALL spend exactly one cycle in FINISH, asserting O_SA_END and O_DONE in that cycle (the same cycle as the final O_Y_VLD), then return to IDLE.
REQ-025 SHALL ignore I_SA_SHIFT in IDLE, START and FINISH, with no counter change.
REQ-026 SHALL make every output a register or a direct decode of state/counter registers, with no combinational path from any input to any output.
REQ-027 SHALL size the drain counter to $clog2(S)+1 bits and the feed and output counters to ROWS_W bits; no counter SHALL wrap within a legal job (M <= 2^ROWS_W-1).

Reset
REQ-028 SHALL, on I_RST_N low (asynchronous, including mid-job), enter IDLE, clear all counters, and drive every output 0 except O_CMD_RDY=1.
REQ-029 SHALL, after reset is released, issue no O_SA_END and no O_DONE for the aborted job.

Structure
REQ-030 SHALL take the state encoding and the default S from shared package sa_pkg.
REQ-031 SHALL be implemented as a single module with no sub-modules.

Verification (S=4, ROWS_W=8)
REQ-032 SHALL cover: M=3 with shift pulses every 5 cycles -> 7 shifts, O_RD_ADDR 0,1,2, O_Y_IDX 0,1,2 one cycle after shifts 5,6,7, O_SA_END/O_DONE with the final O_Y_VLD.
REQ-033 SHALL cover: M=0 -> O_DONE one cycle after acceptance; no O_SA_START, no O_SA_END.
REQ-034 SHALL cover: I_CMD_VLD held high during a job -> no second acceptance until O_CMD_RDY=1, then job 2 restarts O_RD_ADDR at 0.
REQ-035 SHALL cover: I_SA_SHIFT pulsed in IDLE and START -> no counter movement; job result identical to REQ-032.
REQ-036 SHALL cover: reset asserted after shift 2 of M=3 -> all outputs at reset values immediately; no O_DONE; a new M=1 job completes normally after 5 shifts.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array job controller.
package sa_pkg;

    localparam int SA_S_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_FEED   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } sa_state_e;

endpackage

// File: rtl/sa_ctrl.sv
// Job sequencer for an S-deep systolic array: start, feed M rows,
// drain S steps, then report results and completion.
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int S      = SA_S_DEFAULT,
    parameter int ROWS_W = 8
) (
    input  logic              I_CLK,
    input  logic              I_RST_N,
    input  logic              I_CMD_VLD,
    output logic              O_CMD_RDY,
    input  logic [ROWS_W-1:0] I_CMD_ROWS,
    output logic              O_SA_START,
    output logic              O_SA_END,
    input  logic              I_SA_SHIFT,
    output logic [ROWS_W-1:0] O_RD_ADDR,
    output logic              O_X_ZERO,
    output logic              O_Y_VLD,
    output logic [ROWS_W-1:0] O_Y_IDX,
    output logic              O_DONE,
    output logic              O_BUSY
);

    localparam int DW = $clog2(S) + 1;
    localparam int JW = ((ROWS_W > DW) ? ROWS_W : DW) + 2;
    localparam logic [JW-1:0] S_J        = JW'(S);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(S - 1);

    sa_state_e         state_q, state_d;
    logic [ROWS_W-1:0] m_q, m_d;
    logic [ROWS_W-1:0] feed_q, feed_d;
    logic [ROWS_W-1:0] out_q, out_d;
    logic [ROWS_W-1:0] y_idx_q, y_idx_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              y_vld_q, y_vld_d;

    // 1-based number of the shift pulse currently being seen
    logic [JW-1:0] j_feed;
    logic [JW-1:0] j_drain;
    logic          feed_last;

    assign j_feed    = JW'(feed_q) + JW'(1);
    assign j_drain   = JW'(m_q) + JW'(drain_q) + JW'(1);
    assign feed_last = (feed_q == (m_q - ROWS_W'(1)));

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        feed_d  = feed_q;
        out_d   = out_q;
        y_idx_d = y_idx_q;
        drain_d = drain_q;
        y_vld_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (I_CMD_VLD) begin
                    m_d     = I_CMD_ROWS;
                    feed_d  = '0;
                    out_d   = '0;
                    y_idx_d = '0;
                    drain_d = '0;
                    state_d = (I_CMD_ROWS == '0) ? ST_FINISH : ST_START;
                end
            end
            ST_START: state_d = ST_FEED;
            ST_FEED: begin
                if (I_SA_SHIFT) begin
                    if (j_feed > S_J) begin
                        y_vld_d = 1'b1;
                        y_idx_d = out_q;
                        out_d   = out_q + ROWS_W'(1);
                    end
                    if (feed_last) state_d = ST_DRAIN;
                    else feed_d = feed_q + ROWS_W'(1);
                end
            end
            ST_DRAIN: begin
                if (I_SA_SHIFT) begin
                    if (j_drain > S_J) begin
                        y_vld_d = 1'b1;
                        y_idx_d = out_q;
                        out_d   = out_q + ROWS_W'(1);
                    end
                    if (drain_q == DRAIN_LAST) state_d = ST_FINISH;
                    else drain_d = drain_q + DW'(1);
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            feed_q  <= '0;
            out_q   <= '0;
            y_idx_q <= '0;
            drain_q <= '0;
            y_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            feed_q  <= feed_d;
            out_q   <= out_d;
            y_idx_q <= y_idx_d;
            drain_q <= drain_d;
            y_vld_q <= y_vld_d;
        end
    end

    // An empty job never starts the array, so it must not end it either
    assign O_CMD_RDY  = (state_q == ST_IDLE);
    assign O_SA_START = (state_q == ST_START);
    assign O_SA_END   = (state_q == ST_FINISH) && (m_q != '0);
    assign O_RD_ADDR  = feed_q;
    assign O_X_ZERO   = (state_q == ST_DRAIN);
    assign O_Y_VLD    = y_vld_q;
    assign O_Y_IDX    = y_idx_q;
    assign O_DONE     = (state_q == ST_FINISH);
    assign O_BUSY     = (state_q != ST_IDLE);

endmodule
